// File: rtl/pll_reset_sequencer.sv
// Purpose : turns the asynchronous PLL LOCK into a clean, guarded active-low reset for the PLLOUTCORE domain.
// Latency : sresetn rises SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES+1 edges after a steady lock; falls within SYNC_STAGES+1 edges of a loss.
// Backpressure: none; free-running status outputs, no handshake.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      pll_lock,
  output logic                      sresetn,
  output logic                      ready,
  output logic                      lock_lost,
  output logic [LOSS_CNT_WIDTH-1:0] relock_count
);

  // One counter is shared by the stability and hold phases, so size it for the longer one.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_ONE = LOSS_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABILISE = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]    r_sync;
  logic                      w_lock_s;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;

  logic                      r_sresetn;
  logic                      r_lock_lost;
  logic [LOSS_CNT_WIDTH-1:0] r_relock_count;
  logic                      w_lost_nxt;
  logic [LOSS_CNT_WIDTH-1:0] w_relock_nxt;
  logic                      w_relock_sat;

  // Bring pll_lock into the clk domain; only the last stage is ever used.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign w_lock_s     = r_sync[SYNC_STAGES-1];
  assign w_relock_sat = (r_relock_count == {LOSS_CNT_WIDTH{1'b1}});

  // State, counter and all outputs are registered so downstream never sees a combinational reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= S_WAIT_LOCK;
      r_cnt          <= '0;
      r_sresetn      <= 1'b0;
      r_lock_lost    <= 1'b0;
      r_relock_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_sresetn      <= (w_state_nxt == S_RUN);
      r_lock_lost    <= w_lost_nxt;
      r_relock_count <= w_relock_nxt;
    end
  end

  // Next-state logic: any lock drop wins over a phase completing, so a late drop never releases reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lost_nxt   = 1'b0;
    w_relock_nxt = r_relock_count;
    case (r_state)
      S_WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (w_lock_s) begin
          w_state_nxt = S_STABILISE;
        end
      end
      S_STABILISE: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_lost_nxt  = 1'b1;
          if (!w_relock_sat) begin
            w_relock_nxt = r_relock_count + LOSS_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sresetn      = r_sresetn;
  assign ready        = r_sresetn;
  assign lock_lost    = r_lock_lost;
  assign relock_count = r_relock_count;

endmodule
